gsau_wb_buffer: RTL and testbench

Write-back buffer directly downstream of the GSAU control unit. It accepts completed partial-sum rows (512 bits plus an 8-bit destination register) and queues them in a small FIFO. It drains each row into the veggie register file write port in RF_PORT_BITS-wide beats. After the last beat of a row is written, it pulses a completion to the scoreboard.

---
 rtl/gsau_wb_buffer.sv | 144 ++++++++++++++
 tb/tb_gsau_wb_buffer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsau_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : gsau_wb_buffer
// Purpose  : Row FIFO between the GSAU control unit and the vreg file write
//            port; drains each row in RF_PORT_BITS beats and signals completion.
// Revision : 1.0 - initial release
// ============================================================================
module gsau_wb_buffer #(
    parameter  int DEPTH        = 4,
    parameter  int ROW_BITS     = 512,
    parameter  int RF_PORT_BITS = 256,
    localparam int NBEATS       = ROW_BITS / RF_PORT_BITS,
    localparam int BEAT_BITS    = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    wb_valid,
    input  logic [ROW_BITS-1:0]     wb_psum,
    input  logic [7:0]              wb_wbdst,
    output logic                    wb_output_ready,
    output logic                    rf_wen,
    output logic [7:0]              rf_waddr,
    output logic [BEAT_BITS-1:0]    rf_beat,
    output logic [RF_PORT_BITS-1:0] rf_wdata,
    input  logic                    rf_wack,
    output logic                    sb_wb_done,
    output logic [7:0]              sb_wb_vdst,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_ENTRY_W = ROW_BITS + 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    generate
        if ((ROW_BITS % RF_PORT_BITS) != 0) begin : g_bad_ratio
            $error("gsau_wb_buffer: RF_PORT_BITS must divide ROW_BITS");
        end
    endgenerate

    logic [c_ENTRY_W-1:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;
    logic [c_CNT_W-1:0]      w_count_nxt;
    logic [BEAT_BITS-1:0]    r_beat;
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_done;
    logic [7:0]              r_vdst;

    logic                    w_ready;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_last_beat;
    logic [c_ENTRY_W-1:0]    w_head;
    logic [ROW_BITS-1:0]     w_head_psum;
    logic [7:0]              w_head_dst;

    // Ready looks only at the registered count, so a full buffer refuses input
    // even on the cycle its head retires.
    assign w_ready     = (r_count < c_CNT_W'(DEPTH));
    assign w_push      = wb_valid && w_ready;
    assign w_last_beat = (r_beat == BEAT_BITS'(NBEATS - 1));
    assign w_pop       = (r_state == ST_WRITE) && rf_wack && w_last_beat;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_psum = w_head[ROW_BITS-1:0];
    assign w_head_dst  = w_head[c_ENTRY_W-1 -: 8];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_W'(1);
            2'b01:   w_count_nxt = r_count - c_CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {wb_wbdst, wb_psum};
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_beat   <= '0;
            r_state  <= ST_IDLE;
            r_done   <= 1'b0;
            r_vdst   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                r_vdst   <= w_head_dst;
            end
            if ((r_state == ST_WRITE) && rf_wack) begin
                r_beat <= w_last_beat ? '0 : r_beat + BEAT_BITS'(1);
            end
        end
    end

    // WRITE tracks "rows held after this edge", which gives one-cycle
    // push-to-request latency from an empty buffer.
    always_comb begin
        w_state_nxt = (w_count_nxt != '0) ? ST_WRITE : ST_IDLE;
        rf_wen      = 1'b0;
        rf_waddr    = '0;
        rf_beat     = '0;
        rf_wdata    = '0;
        case (r_state)
            ST_WRITE: begin
                rf_wen   = 1'b1;
                rf_waddr = w_head_dst;
                rf_beat  = r_beat;
                rf_wdata = w_head_psum[32'(r_beat) * RF_PORT_BITS +: RF_PORT_BITS];
            end
            default: begin
                rf_wen = 1'b0;
            end
        endcase
    end

    assign wb_output_ready = w_ready;
    assign sb_wb_done      = r_done;
    assign sb_wb_vdst      = r_vdst;
    assign occupancy       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_gsau_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gsau_wb_buffer
// Purpose  : Directed scoreboard bench for gsau_wb_buffer (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gsau_wb_buffer;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic         wb_valid = 1'b0;
    logic [511:0] wb_psum = '0;
    logic [7:0]   wb_wbdst = '0;
    logic         wb_output_ready;
    logic         rf_wen;
    logic [7:0]   rf_waddr;
    logic [0:0]   rf_beat;
    logic [255:0] rf_wdata;
    logic         rf_wack = 1'b0;
    logic         sb_wb_done;
    logic [7:0]   sb_wb_vdst;
    logic [2:0]   occupancy;

    gsau_wb_buffer #(.DEPTH(4), .ROW_BITS(512), .RF_PORT_BITS(256)) dut (
        .CLK(CLK), .nRST(nRST),
        .wb_valid(wb_valid), .wb_psum(wb_psum), .wb_wbdst(wb_wbdst),
        .wb_output_ready(wb_output_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_beat(rf_beat),
        .rf_wdata(rf_wdata), .rf_wack(rf_wack),
        .sb_wb_done(sb_wb_done), .sb_wb_vdst(sb_wb_vdst),
        .occupancy(occupancy)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0]   dst;
        logic [0:0]   beat;
        logic [255:0] data;
    } beat_t;

    beat_t      exp_beats[$];
    logic [7:0] exp_done[$];
    int         n_vec  = 0;
    int         n_miss = 0;

    function automatic logic [511:0] mk_psum(input logic [7:0] dst);
        logic [255:0] lo;
        logic [255:0] hi;
        lo = {8{dst, 8'h11, 8'h22, 8'h33}};
        hi = {8{8'hC0, dst, 8'hEE, 8'h77}};
        return {hi, lo};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one row for one edge; the expected beats/done are queued only
    // when the hand-computed plan says the buffer should take it.
    task automatic push_row(input logic [7:0] dst, input logic accept);
        logic [511:0] p;
        p        = mk_psum(dst);
        wb_valid = 1'b1;
        wb_wbdst = dst;
        wb_psum  = p;
        @(negedge CLK);
        chk("push_ready", 256'(wb_output_ready), 256'(accept));
        if (accept) begin
            exp_beats.push_back('{dst: dst, beat: 1'b0, data: p[255:0]});
            exp_beats.push_back('{dst: dst, beat: 1'b1, data: p[511:256]});
            exp_done.push_back(dst);
        end
        @(posedge CLK);
        #1;
        wb_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge CLK);
            cycles++;
            if (sb_wb_done) return;
        end
        n_vec++;
        n_miss++;
        $display("FAIL wait_done: no completion within %0d cycles", budget);
        cycles = -1;
    endtask

    // Monitor: every accepted beat and every completion is matched in order.
    always @(negedge CLK) begin
        if (nRST) begin
            if (rf_wen && rf_wack) begin
                n_vec++;
                if (exp_beats.size() == 0) begin
                    n_miss++;
                    $display("FAIL beat_unexpected: got dst=%0h beat=%0d expected none", rf_waddr, rf_beat);
                end else begin
                    beat_t e;
                    e = exp_beats.pop_front();
                    if (rf_waddr !== e.dst || rf_beat !== e.beat || rf_wdata !== e.data) begin
                        n_miss++;
                        $display("FAIL beat: got dst=%0h beat=%0d data=%0h expected dst=%0h beat=%0d data=%0h",
                                 rf_waddr, rf_beat, rf_wdata, e.dst, e.beat, e.data);
                    end
                end
            end
            if (sb_wb_done) begin
                n_vec++;
                if (exp_done.size() == 0) begin
                    n_miss++;
                    $display("FAIL done_unexpected: got vdst=%0h expected no pulse", sb_wb_vdst);
                end else begin
                    logic [7:0] ed;
                    ed = exp_done.pop_front();
                    if (sb_wb_vdst !== ed) begin
                        n_miss++;
                        $display("FAIL done_vdst: got %0h expected %0h", sb_wb_vdst, ed);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           cyc;
        logic         seen;
        logic [511:0] p;
        logic [7:0]   hold_addr;
        logic [255:0] hold_data;

        // Reset then idle
        #2;
        chk("rst_ready", 256'(wb_output_ready), 256'(1));
        chk("rst_wen", 256'(rf_wen), 256'(0));
        chk("rst_occ", 256'(occupancy), 256'(0));
        chk("rst_done", 256'(sb_wb_done), 256'(0));
        chk("rst_wdata", rf_wdata, 256'(0));
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            if (sb_wb_done || rf_wen || occupancy != 3'd0 || !wb_output_ready) seen = 1'b1;
        end
        chk("idle_quiet", 256'(seen), 256'(0));

        // Single row, acknowledged every cycle
        rf_wack = 1'b1;
        @(posedge CLK);
        #1;
        p = mk_psum(8'h12);
        push_row(8'h12, 1'b1);
        @(negedge CLK);
        chk("single_wen_c1", 256'(rf_wen), 256'(1));
        chk("single_beat_c1", 256'(rf_beat), 256'(0));
        chk("single_data_c1", rf_wdata, p[255:0]);
        chk("single_occ_c1", 256'(occupancy), 256'(1));
        @(negedge CLK);
        chk("single_beat_c2", 256'(rf_beat), 256'(1));
        chk("single_data_c2", rf_wdata, p[511:256]);
        @(negedge CLK);
        chk("single_done_c3", 256'(sb_wb_done), 256'(1));
        chk("single_vdst_c3", 256'(sb_wb_vdst), 256'(8'h12));
        chk("single_occ_c3", 256'(occupancy), 256'(0));
        chk("single_wen_c3", 256'(rf_wen), 256'(0));
        @(negedge CLK);
        chk("single_done_c4", 256'(sb_wb_done), 256'(0));
        chk("single_vdst_hold", 256'(sb_wb_vdst), 256'(8'h12));

        // Backpressure on beat 1
        @(posedge CLK);
        #1;
        p = mk_psum(8'h34);
        push_row(8'h34, 1'b1);
        @(posedge CLK);
        #1 rf_wack = 1'b0;
        hold_addr = 8'h34;
        hold_data = p[511:256];
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("bp_beat", 256'(rf_beat), 256'(1));
            chk("bp_addr", 256'(rf_waddr), 256'(hold_addr));
            chk("bp_data", rf_wdata, hold_data);
        end
        @(posedge CLK);
        #1 rf_wack = 1'b1;
        wait_done(10, cyc);
        chk("bp_done_latency", 256'(cyc), 256'(2));

        // Fill to full with the write port stalled
        @(posedge CLK);
        #1 rf_wack = 1'b0;
        push_row(8'd1, 1'b1);
        push_row(8'd2, 1'b1);
        push_row(8'd3, 1'b1);
        push_row(8'd4, 1'b1);
        push_row(8'd5, 1'b0);
        @(negedge CLK);
        chk("full_occ", 256'(occupancy), 256'(4));
        chk("full_ready", 256'(wb_output_ready), 256'(0));
        @(posedge CLK);
        #1 rf_wack = 1'b1;
        wait_done(10, cyc);
        for (int k = 0; k < 3; k++) begin
            wait_done(10, cyc);
            chk("full_done_spacing", 256'(cyc), 256'(2));
        end
        @(negedge CLK);
        chk("full_drained_occ", 256'(occupancy), 256'(0));

        // Continuous push every two cycles with pops overlapping pushes
        @(posedge CLK);
        #1;
        for (int i = 0; i < 10; i++) begin
            push_row(8'h50 + 8'(i % 3), 1'b1);
            @(negedge CLK);
            chk("stream_occ_le1", 256'(occupancy <= 3'd1), 256'(1));
            @(posedge CLK);
            #1;
        end
        wait_done(10, cyc);
        repeat (3) @(negedge CLK);
        chk("stream_occ_end", 256'(occupancy), 256'(0));

        // Reset during beat 1 of the first of three queued rows
        @(posedge CLK);
        #1 rf_wack = 1'b0;
        push_row(8'h61, 1'b1);
        push_row(8'h62, 1'b1);
        push_row(8'h63, 1'b1);
        rf_wack = 1'b1;
        @(posedge CLK);
        #1 rf_wack = 1'b0;
        @(negedge CLK);
        chk("mid_beat1", 256'(rf_beat), 256'(1));
        #1;
        nRST = 1'b0;
        exp_beats.delete();
        exp_done.delete();
        #1;
        chk("mid_rst_wen", 256'(rf_wen), 256'(0));
        chk("mid_rst_ready", 256'(wb_output_ready), 256'(1));
        chk("mid_rst_occ", 256'(occupancy), 256'(0));
        chk("mid_rst_addr", 256'(rf_waddr), 256'(0));
        chk("mid_rst_beat", 256'(rf_beat), 256'(0));
        chk("mid_rst_vdst", 256'(sb_wb_vdst), 256'(0));
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        rf_wack = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            if (sb_wb_done || rf_wen || occupancy != 3'd0) seen = 1'b1;
        end
        chk("post_rst_quiet", 256'(seen), 256'(0));

        chk("beats_outstanding", 256'(exp_beats.size()), 256'(0));
        chk("done_outstanding", 256'(exp_done.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
